// File: rtl/comp_feed_seq_pkg.sv
// Shared definitions for the comparator feed sequencer: default widths, FSM states,
// and the buffer address helper.
package comp_feed_seq_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Buffer address of element `offset` of a stream starting at `base`; wraps modulo 2^ADDR_W_DEF.
    function automatic logic [ADDR_W_DEF-1:0] stream_addr(input logic [ADDR_W_DEF-1:0] base,
                                                          input logic [ADDR_W_DEF-1:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/comp_feed_seq_if.sv
// Bundle of the control, buffer-read and comparator-feed signals around comp_feed_seq.
// The sequencer uses the master view; the environment (buffer arbiter, comparator, controller) uses slave.
interface comp_feed_seq_if
    import comp_feed_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] len;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic [DATA_W-1:0] mem_data;
    logic              comp_rst;
    logic              comp_en;
    logic [DATA_W-1:0] comp_data;
    logic [ADDR_W-1:0] idx;
    logic              busy;
    logic              done;

    modport master (
        input  start, base_addr, len, mem_gnt, mem_data,
        output mem_rd_en, mem_addr, comp_rst, comp_en, comp_data, idx, busy, done
    );

    modport slave (
        output start, base_addr, len, mem_gnt, mem_data,
        input  mem_rd_en, mem_addr, comp_rst, comp_en, comp_data, idx, busy, done
    );
endinterface

// File: rtl/comp_feed_seq.sv
// Clears the comparator, streams LEN buffer words through an arbitrated read port into it,
// then pulses done one cycle after the last word.
module comp_feed_seq
    import comp_feed_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    comp_feed_seq_if.master bus
);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] len_reg;
    logic [ADDR_W-1:0] issued_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic              rd_pend_reg;
    logic              comp_en_reg;
    logic [DATA_W-1:0] comp_data_reg;

    logic              rd_en;
    logic              comp_rst;
    logic              rd_fire;
    logic              last_issue;

    assign rd_fire    = rd_en & bus.mem_gnt;
    assign last_issue = (issued_reg == (len_reg - ADDR_W'(1)));

    always_comb begin
        state_next = state_reg;
        rd_en      = 1'b0;
        comp_rst   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = CLR;
                end
            end
            CLR: begin
                comp_rst   = 1'b1;
                state_next = (len_reg == '0) ? DONE : RUN;
            end
            RUN: begin
                rd_en = 1'b1;
                if (bus.mem_gnt && last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The final word is on comp_data and nothing is still in flight.
                if (comp_en_reg && !rd_pend_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            base_reg      <= '0;
            len_reg       <= '0;
            issued_reg    <= '0;
            idx_reg       <= '0;
            rd_pend_reg   <= 1'b0;
            comp_en_reg   <= 1'b0;
            comp_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && bus.start) begin
                base_reg <= bus.base_addr;
                len_reg  <= bus.len;
            end
            if (state_reg == CLR) begin
                issued_reg <= '0;
                idx_reg    <= '0;
            end else begin
                if (rd_fire) begin
                    issued_reg <= issued_reg + ADDR_W'(1);
                end
                if (comp_en_reg) begin
                    idx_reg <= idx_reg + ADDR_W'(1);
                end
            end
            // One-stage read return: data arrives the cycle after grant, then is registered.
            rd_pend_reg <= rd_fire;
            comp_en_reg <= rd_pend_reg;
            if (rd_pend_reg) begin
                comp_data_reg <= bus.mem_data;
            end
        end
    end

    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = stream_addr(base_reg, issued_reg);
    assign bus.comp_rst  = comp_rst;
    assign bus.comp_en   = comp_en_reg;
    assign bus.comp_data = comp_data_reg;
    assign bus.idx       = idx_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = (state_reg == DONE);

endmodule

// File: tb/tb_comp_feed_seq.sv
// Directed bench for comp_feed_seq: per-cycle capture of one operation, then scenario checks
// against hand-computed cycle numbers, data and addresses.
module tb_comp_feed_seq;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int NC = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    comp_feed_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
    comp_feed_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_rd_en && bus.mem_gnt) bus.mem_data <= mem[bus.mem_addr];
    end

    int total = 0;
    int bad   = 0;

    logic gnt_s [0:NC];
    logic start_s [0:NC];
    logic rst_s [0:NC];

    logic          rst_c  [0:NC];
    logic          done_c [0:NC];
    logic          busy_c [0:NC];
    logic          rd_c   [0:NC];
    logic          en_c   [0:NC];
    logic [AW-1:0] addr_c [0:NC];
    logic [DW-1:0] data_c [0:NC];
    logic [AW-1:0] idx_c  [0:NC];
    int            en_cyc [$];
    logic [DW-1:0] en_data [$];
    logic [AW-1:0] en_idx [$];
    logic [AW-1:0] acc [$];
    logic          ovl;

    task automatic clear_sched();
        for (int c = 0; c <= NC; c++) begin
            gnt_s[c] = 1'b1; start_s[c] = 1'b0; rst_s[c] = 1'b0;
        end
    endtask

    task automatic sample(input int c);
        rst_c[c]  = bus.comp_rst;
        done_c[c] = bus.done;
        busy_c[c] = bus.busy;
        rd_c[c]   = bus.mem_rd_en;
        en_c[c]   = bus.comp_en;
        addr_c[c] = bus.mem_addr;
        data_c[c] = bus.comp_data;
        idx_c[c]  = bus.idx;
        if (bus.comp_en === 1'b1) begin
            en_cyc.push_back(c); en_data.push_back(bus.comp_data); en_idx.push_back(bus.idx);
        end
        if (bus.mem_rd_en === 1'b1 && bus.mem_gnt === 1'b1) acc.push_back(bus.mem_addr);
        if (bus.comp_rst === 1'b1 && bus.comp_en === 1'b1) ovl = 1'b1;
    endtask

    // Cycle 0 is the cycle start is high; outputs are sampled at each negedge.
    task automatic run_op(input logic [AW-1:0] base, input logic [AW-1:0] len);
        en_cyc.delete(); en_data.delete(); en_idx.delete(); acc.delete(); ovl = 1'b0;
        @(posedge clk); #1;
        bus.base_addr = base; bus.len = len; bus.start = 1'b1;
        bus.mem_gnt = gnt_s[0]; rst = rst_s[0];
        @(negedge clk); sample(0);
        for (int c = 1; c <= NC; c++) begin
            @(posedge clk); #1;
            bus.start = start_s[c]; bus.mem_gnt = gnt_s[c]; rst = rst_s[c];
            @(negedge clk); sample(c);
        end
        bus.start = 1'b0; bus.mem_gnt = 1'b1; rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.mem_gnt = 1'b1; bus.base_addr = '0; bus.len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.comp_en !== 1'b0) begin bad++; $display("FAIL reset_comp_en: got %b want 0", bus.comp_en); end
        total++; if (bus.comp_rst !== 1'b0) begin bad++; $display("FAIL reset_comp_rst: got %b want 0", bus.comp_rst); end
        total++; if (bus.mem_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", bus.mem_rd_en); end
        total++; if (bus.comp_data !== 16'h0) begin bad++; $display("FAIL reset_data: got %h want 0000", bus.comp_data); end
        total++; if (bus.idx !== 8'h0) begin bad++; $display("FAIL reset_idx: got %h want 00", bus.idx); end
        rst = 1'b0;
        $display("reset: checked");
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_d [4] = '{16'h0005, 16'hFFF0, 16'h0007, 16'h0003};
        mem[8'h10] = 16'h0005; mem[8'h11] = 16'hFFF0; mem[8'h12] = 16'h0007; mem[8'h13] = 16'h0003;
        clear_sched();
        run_op(8'h10, 8'd4);
        total++; if (rst_c[1] !== 1'b1 || rst_c[2] !== 1'b0) begin bad++; $display("FAIL basic_comp_rst: got @1=%b @2=%b want 1,0", rst_c[1], rst_c[2]); end
        total++; if (en_cyc.size() != 4) begin bad++; $display("FAIL basic_en_count: got %0d want 4", en_cyc.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (en_cyc[i] != 4 + i) begin bad++; $display("FAIL basic_en_cycle[%0d]: got %0d want %0d", i, en_cyc[i], 4 + i); end
                total++; if (en_data[i] !== exp_d[i]) begin bad++; $display("FAIL basic_data[%0d]: got %h want %h", i, en_data[i], exp_d[i]); end
                total++; if (en_idx[i] !== AW'(i)) begin bad++; $display("FAIL basic_idx[%0d]: got %0d want %0d", i, en_idx[i], i); end
            end
        end
        total++; if (acc.size() != 4 || acc[0] !== 8'h10 || acc[3] !== 8'h13) begin bad++; $display("FAIL basic_addrs: got n=%0d", acc.size()); end
        total++; if (done_c[7] !== 1'b0 || done_c[8] !== 1'b1 || done_c[9] !== 1'b0) begin bad++; $display("FAIL basic_done: got @7..9=%b%b%b want 010", done_c[7], done_c[8], done_c[9]); end
        total++; if (busy_c[8] !== 1'b1 || busy_c[9] !== 1'b0) begin bad++; $display("FAIL basic_busy: got @8=%b @9=%b want 1,0", busy_c[8], busy_c[9]); end
        total++; if (ovl !== 1'b0) begin bad++; $display("FAIL basic_rst_en_overlap: got %b want 0", ovl); end
        $display("basic: base=10 len=4 en_pulses=%0d", en_cyc.size());
    endtask

    task automatic test_len_zero();
        int rd_n = 0;
        clear_sched();
        run_op(8'h20, 8'd0);
        for (int c = 0; c <= NC; c++) if (rd_c[c] !== 1'b0) rd_n++;
        total++; if (rst_c[1] !== 1'b1) begin bad++; $display("FAIL len0_comp_rst: got %b want 1", rst_c[1]); end
        total++; if (done_c[2] !== 1'b1) begin bad++; $display("FAIL len0_done: got %b want 1", done_c[2]); end
        total++; if (rd_n != 0) begin bad++; $display("FAIL len0_rd_en: got %0d cycles want 0", rd_n); end
        total++; if (en_cyc.size() != 0) begin bad++; $display("FAIL len0_comp_en: got %0d want 0", en_cyc.size()); end
        total++; if (busy_c[3] !== 1'b0) begin bad++; $display("FAIL len0_busy: got %b want 0", busy_c[3]); end
        $display("len0: done at cycle 2 expected");
    endtask

    task automatic test_stall();
        int            exp_c [3] = '{4, 7, 8};
        logic [DW-1:0] exp_d [3] = '{16'h1111, 16'h2222, 16'h3333};
        mem[8'h40] = 16'h1111; mem[8'h41] = 16'h2222; mem[8'h42] = 16'h3333;
        clear_sched();
        gnt_s[3] = 1'b0; gnt_s[4] = 1'b0;
        run_op(8'h40, 8'd3);
        for (int c = 3; c <= 5; c++) begin
            total++; if (rd_c[c] !== 1'b1 || addr_c[c] !== 8'h41) begin bad++; $display("FAIL stall_addr@%0d: got en=%b addr=%h want 1,41", c, rd_c[c], addr_c[c]); end
        end
        total++; if (en_cyc.size() != 3) begin bad++; $display("FAIL stall_en_count: got %0d want 3", en_cyc.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                total++; if (en_cyc[i] != exp_c[i] || en_data[i] !== exp_d[i] || en_idx[i] !== AW'(i)) begin
                    bad++; $display("FAIL stall_word[%0d]: got cyc=%0d data=%h idx=%0d want %0d %h %0d", i, en_cyc[i], en_data[i], en_idx[i], exp_c[i], exp_d[i], i);
                end
            end
        end
        total++; if (done_c[8] !== 1'b0 || done_c[9] !== 1'b1) begin bad++; $display("FAIL stall_done: got @8=%b @9=%b want 0,1", done_c[8], done_c[9]); end
        $display("stall: len=3 gnt gap 2 cycles");
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        logic [DW-1:0] exp_d [4] = '{16'hA0FE, 16'hA0FF, 16'hA000, 16'hA001};
        for (int i = 0; i < 4; i++) mem[exp_a[i]] = exp_d[i];
        clear_sched();
        run_op(8'hFE, 8'd4);
        total++; if (acc.size() != 4) begin bad++; $display("FAIL wrap_addr_count: got %0d want 4", acc.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (acc[i] !== exp_a[i]) begin bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, acc[i], exp_a[i]); end
            end
        end
        total++; if (en_cyc.size() != 4) begin bad++; $display("FAIL wrap_en_count: got %0d want 4", en_cyc.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (en_data[i] !== exp_d[i]) begin bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, en_data[i], exp_d[i]); end
            end
        end
        $display("wrap: base=FE len=4");
    endtask

    task automatic test_abort();
        int late_en = 0;
        int done_n  = 0;
        int busy_n  = 0;
        clear_sched();
        mem[8'h10] = 16'h0005; mem[8'h11] = 16'hFFF0; mem[8'h12] = 16'h0007; mem[8'h13] = 16'h0003;
        rst_s[6] = 1'b1; start_s[6] = 1'b1;
        run_op(8'h10, 8'd4);
        total++; if (en_c[7] !== 1'b0 || done_c[7] !== 1'b0 || busy_c[7] !== 1'b0 || rd_c[7] !== 1'b0 || rst_c[7] !== 1'b0) begin
            bad++; $display("FAIL abort_ctrl@7: got en=%b done=%b busy=%b rd=%b crst=%b want all 0", en_c[7], done_c[7], busy_c[7], rd_c[7], rst_c[7]);
        end
        total++; if (data_c[7] !== 16'h0 || idx_c[7] !== 8'h0) begin bad++; $display("FAIL abort_data@7: got data=%h idx=%h want 0000 00", data_c[7], idx_c[7]); end
        foreach (en_cyc[i]) if (en_cyc[i] > 6) late_en++;
        for (int c = 0; c <= NC; c++) if (done_c[c] === 1'b1) done_n++;
        for (int c = 7; c <= NC; c++) if (busy_c[c] !== 1'b0) busy_n++;
        total++; if (late_en != 0) begin bad++; $display("FAIL abort_late_en: got %0d want 0", late_en); end
        total++; if (done_n != 0) begin bad++; $display("FAIL abort_done: got %0d want 0", done_n); end
        total++; if (busy_n != 0) begin bad++; $display("FAIL abort_start_with_rst: got busy cycles=%0d want 0", busy_n); end
        $display("abort: rst in DRAIN at cycle 6");
        test_basic();
    endtask

    task automatic test_restart();
        int done_n = 0;
        clear_sched();
        start_s[3] = 1'b1;
        run_op(8'h10, 8'd4);
        for (int c = 0; c <= NC; c++) if (done_c[c] === 1'b1) done_n++;
        total++; if (en_cyc.size() != 4) begin bad++; $display("FAIL restart_en_count: got %0d want 4", en_cyc.size()); end
        total++; if (done_n != 1 || done_c[8] !== 1'b1) begin bad++; $display("FAIL restart_done: got count=%0d @8=%b want 1,1", done_n, done_c[8]); end
        $display("restart: start re-pulsed in RUN");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_len_zero();
        test_stall();
        test_wrap();
        test_abort();
        test_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
